rv_lsu_unit: RTL and testbench

RV_LSU_UNIT -- requirements
Module: rv_lsu_unit

---
 rtl/rv_lsu_unit.sv | 219 +++++++++++++++++++++
 tb/tb_rv_lsu_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu_unit.sv
// Load/store unit that connects a core-side request port to a single-beat data bus.
// Loads and stores that cross a bus word are split into two beats when MISALIGN_EN=1.
// When MISALIGN_EN=0 they are reported as errors instead.
//
// Package rv_lsu_pkg : access-size codes carried on lsu_size_i.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   lsu_req_i .. lsu_wdata_i  core request (held until lsu_valid_o)
//   lsu_rdata_o, lsu_valid_o, lsu_err_o, lsu_stall_o  core response
//   data_req_o, data_gnt_i, data_we_o, data_addr_o, data_be_o, data_wdata_o  bus request
//   data_rvalid_i, data_rdata_i  bus response

package rv_lsu_pkg;
    localparam int unsigned MEM_ACCESS_W = 3;
    localparam logic [MEM_ACCESS_W-1:0] WORD  = 3'd0;
    localparam logic [MEM_ACCESS_W-1:0] HALF  = 3'd1;
    localparam logic [MEM_ACCESS_W-1:0] BYTE  = 3'd2;
    localparam logic [MEM_ACCESS_W-1:0] UHALF = 3'd3;
    localparam logic [MEM_ACCESS_W-1:0] UBYTE = 3'd4;
    localparam logic [MEM_ACCESS_W-1:0] DWORD = 3'd5;
    localparam logic [MEM_ACCESS_W-1:0] UWORD = 3'd6;
endpackage

module rv_lsu_unit
    import rv_lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
    input  logic [XLEN-1:0]         lsu_addr_i,
    input  logic [XLEN-1:0]         lsu_wdata_i,
    output logic [XLEN-1:0]         lsu_rdata_o,
    output logic                    lsu_valid_o,
    output logic                    lsu_err_o,
    output logic                    lsu_stall_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic                    data_we_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN/8-1:0]       data_be_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StDone} state_e;

    state_e                  state_q;
    logic [XLEN-1:0]         addr_q;
    logic                    we_q;
    logic [MEM_ACCESS_W-1:0] size_q;
    logic [XLEN-1:0]         wdata_q;
    logic [XLEN-1:0]         rlo_q;

    logic [XLEN-1:0]         sel_addr;
    logic                    sel_we;
    logic [MEM_ACCESS_W-1:0] sel_size;
    logic [XLEN-1:0]         sel_wdata;
    logic [OW-1:0]           off;
    logic [3:0]              nbytes;
    int                      span;
    logic                    split;
    logic                    illegal;
    logic                    is_signed;
    logic [2*NB-1:0]         lane_mask;
    logic [2*XLEN-1:0]       shifted;
    logic [2*XLEN-1:0]       wide_wdata;
    logic [2*XLEN-1:0]       rd_wide;
    logic [XLEN-1:0]         rd_raw;
    logic [XLEN-1:0]         ext_mask;
    logic                    sign_bit;
    logic [XLEN-1:0]         load_result;
    logic [XLEN-1:0]         beat1_addr;
    logic [XLEN-1:0]         beat2_addr;

    assign lsu_stall_o = lsu_req_i & ~lsu_valid_o;

    // In IDLE the request inputs drive the beat planning directly, so the first beat
    // can be registered on the accepting edge; afterwards only latched values are used.
    always_comb begin
        sel_addr  = (state_q == StIdle) ? lsu_addr_i  : addr_q;
        sel_we    = (state_q == StIdle) ? lsu_we_i    : we_q;
        sel_size  = (state_q == StIdle) ? lsu_size_i  : size_q;
        sel_wdata = (state_q == StIdle) ? lsu_wdata_i : wdata_q;
        off       = sel_addr[OW-1:0];

        case (sel_size)
            BYTE, UBYTE:  nbytes = 4'd1;
            HALF, UHALF:  nbytes = 4'd2;
            WORD, UWORD:  nbytes = 4'd4;
            DWORD:        nbytes = 4'd8;
            default:      nbytes = 4'd0;
        endcase
        is_signed = (sel_size == WORD) || (sel_size == HALF) || (sel_size == BYTE);

        span    = int'(off) + int'(nbytes);
        split   = span > int'(NB);
        illegal = (nbytes == 4'd0)
               || (sel_we && ((sel_size == UHALF) || (sel_size == UBYTE) || (sel_size == UWORD)))
               || ((XLEN == 32) && ((sel_size == DWORD) || (sel_size == UWORD)))
               || (split && !MISALIGN_EN);

        // Lanes [NB-1:0] belong to beat 1, lanes [2*NB-1:NB] to beat 2.
        for (int i = 0; i < 2 * NB; i++) begin
            lane_mask[i] = (i >= int'(off)) && (i < span);
        end
        shifted = {{XLEN{1'b0}}, sel_wdata} << {off, 3'b000};
        for (int i = 0; i < 2 * NB; i++) begin
            wide_wdata[8*i +: 8] = lane_mask[i] ? shifted[8*i +: 8] : 8'h00;
        end

        beat1_addr = {sel_addr[XLEN-1:OW], {OW{1'b0}}};
        beat2_addr = beat1_addr + XLEN'(NB);

        // Beat 1 data sits below beat 2 data; shifting by the offset aligns the access.
        rd_wide = (state_q == StWait2) ? {data_rdata_i, rlo_q} : {{XLEN{1'b0}}, data_rdata_i};
        rd_raw  = XLEN'(rd_wide >> {off, 3'b000});
        for (int i = 0; i < NB; i++) begin
            ext_mask[8*i +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
        end
        sign_bit = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == 8 * int'(nbytes) - 1) sign_bit = rd_raw[i];
        end
        load_result = (rd_raw & ext_mask) | ((is_signed && sign_bit) ? ~ext_mask : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            wdata_q      <= '0;
            rlo_q        <= '0;
            lsu_rdata_o  <= '0;
            lsu_valid_o  <= 1'b0;
            lsu_err_o    <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= '0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (lsu_req_i) begin
                        addr_q  <= lsu_addr_i;
                        we_q    <= lsu_we_i;
                        size_q  <= lsu_size_i;
                        wdata_q <= lsu_wdata_i;
                        if (illegal) begin
                            state_q     <= StDone;
                            lsu_valid_o <= 1'b1;
                            lsu_err_o   <= 1'b1;
                            lsu_rdata_o <= '0;
                        end else begin
                            state_q      <= StReq1;
                            lsu_err_o    <= 1'b0;
                            data_req_o   <= 1'b1;
                            data_we_o    <= lsu_we_i;
                            data_addr_o  <= beat1_addr;
                            data_be_o    <= lane_mask[NB-1:0];
                            data_wdata_o <= wide_wdata[XLEN-1:0];
                        end
                    end
                end
                StReq1: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= StWait1;
                    end
                end
                StWait1: begin
                    if (data_rvalid_i) begin
                        rlo_q <= data_rdata_i;
                        if (split) begin
                            state_q      <= StReq2;
                            data_req_o   <= 1'b1;
                            data_addr_o  <= beat2_addr;
                            data_be_o    <= lane_mask[2*NB-1:NB];
                            data_wdata_o <= wide_wdata[2*XLEN-1:XLEN];
                        end else begin
                            state_q     <= StDone;
                            lsu_valid_o <= 1'b1;
                            lsu_rdata_o <= we_q ? '0 : load_result;
                        end
                    end
                end
                StReq2: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= StWait2;
                    end
                end
                StWait2: begin
                    if (data_rvalid_i) begin
                        state_q     <= StDone;
                        lsu_valid_o <= 1'b1;
                        lsu_rdata_o <= we_q ? '0 : load_result;
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    lsu_valid_o <= 1'b0;
                    lsu_err_o   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_lsu_unit.sv
// Scoreboard bench for rv_lsu_unit: stimulus pushes expected bus beats and completions,
// a monitor pops and compares them whenever the DUT presents a beat or a completion.
module tb_rv_lsu_unit;
    import rv_lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rv_delay = 0;

    beat_t       beat_q[$];
    exp_t        exp_q[$];
    logic [31:0] rdq[$];

    logic clk = 1'b0;
    logic rst;
    logic rst_na;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (XLEN=32, MISALIGN_EN=1)
    logic        lsu_req, lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        lsu_valid, lsu_err, lsu_stall;
    logic        data_req, data_gnt, data_we, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;

    rv_lsu_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_rdata_o(lsu_rdata), .lsu_valid_o(lsu_valid), .lsu_err_o(lsu_err),
        .lsu_stall_o(lsu_stall), .data_req_o(data_req), .data_gnt_i(data_gnt),
        .data_we_o(data_we), .data_addr_o(data_addr), .data_be_o(data_be),
        .data_wdata_o(data_wdata), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
    );

    // Second DUT with splitting disabled; its bus never grants
    logic        req_na, valid_na, err_na, stall_na, dreq_na, dwe_na;
    logic [2:0]  size_na;
    logic [31:0] addr_na, rdata_na, daddr_na, dwdata_na;
    logic [3:0]  be_na;

    rv_lsu_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_na (
        .clk_i(clk), .rst_i(rst_na), .lsu_req_i(req_na), .lsu_we_i(1'b0),
        .lsu_size_i(size_na), .lsu_addr_i(addr_na), .lsu_wdata_i(32'h0),
        .lsu_rdata_o(rdata_na), .lsu_valid_o(valid_na), .lsu_err_o(err_na),
        .lsu_stall_o(stall_na), .data_req_o(dreq_na), .data_gnt_i(1'b0),
        .data_we_o(dwe_na), .data_addr_o(daddr_na), .data_be_o(be_na),
        .data_wdata_o(dwdata_na), .data_rvalid_i(1'b0), .data_rdata_i(32'h0)
    );

    // 64-bit DUT driven by hand
    logic        req64, valid64, err64, stall64, dreq64, dwe64, gnt64, rvalid64;
    logic [2:0]  size64;
    logic [63:0] addr64, rdata64_o, daddr64, dwdata64, rdata64_i;
    logic [7:0]  be64;

    rv_lsu_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) dut64 (
        .clk_i(clk), .rst_i(rst), .lsu_req_i(req64), .lsu_we_i(1'b0),
        .lsu_size_i(size64), .lsu_addr_i(addr64), .lsu_wdata_i(64'h0),
        .lsu_rdata_o(rdata64_o), .lsu_valid_o(valid64), .lsu_err_o(err64),
        .lsu_stall_o(stall64), .data_req_o(dreq64), .data_gnt_i(gnt64),
        .data_we_o(dwe64), .data_addr_o(daddr64), .data_be_o(be64),
        .data_wdata_o(dwdata64), .data_rvalid_i(rvalid64), .data_rdata_i(rdata64_i)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Bus responder: grants immediately, answers rv_delay+1 cycles after the grant.
    initial begin
        int cnt;
        cnt = 0;
        data_gnt = 1'b0;
        data_rvalid = 1'b0;
        data_rdata = 32'h0;
        forever begin
            @(negedge clk);
            data_rvalid = 1'b0;
            data_rdata  = 32'h0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    data_rvalid = 1'b1;
                    if (rdq.size() > 0) data_rdata = rdq.pop_front();
                end
            end
            data_gnt = data_req;
            if (data_req) cnt = 1 + rv_delay;
        end
    end

    // Monitor for the main DUT
    initial begin
        beat_t b;
        exp_t  e;
        @(negedge rst);
        forever begin
            @(negedge clk);
            #1;
            check("stall", lsu_stall, lsu_req & ~lsu_valid);
            if (data_req && data_gnt) begin
                if (beat_q.size() == 0) begin
                    check("unexpected beat", 1'b1, 1'b0);
                end else begin
                    b = beat_q.pop_front();
                    check("beat we", data_we, b.we);
                    check("beat addr", data_addr, b.addr);
                    check("beat be", data_be, b.be);
                    if (b.we) check("beat wdata", data_wdata, b.wdata);
                end
            end
            if (lsu_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected lsu_valid", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", lsu_rdata, e.rdata);
                    check("err", lsu_err, e.err);
                    check("latency cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
        beat_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = wd;
        beat_q.push_back(b);
    endtask

    task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic [31:0] exp_rd,
                          input logic exp_err);
        exp_t e;
        int   n;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = a; lsu_wdata = wd;
        e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble everything but req after acceptance; the DUT must ignore it.
        lsu_addr = ~a; lsu_wdata = ~wd; lsu_size = BYTE; lsu_we = ~we;
        n = 0;
        while (!lsu_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("completion timeout", 1'b1, 1'b0);
        lsu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic t64(input logic [2:0] size, input logic [63:0] a, input logic [63:0] rd,
                       input logic [7:0] exp_be, input logic [63:0] exp, input string nm);
        @(negedge clk);
        req64 = 1'b1; size64 = size; addr64 = a;
        @(negedge clk);
        check({nm, " req"}, dreq64, 1'b1);
        check({nm, " addr"}, daddr64, {a[63:3], 3'b000});
        check({nm, " be"}, be64, exp_be);
        gnt64 = 1'b1;
        @(negedge clk);
        gnt64 = 1'b0; rvalid64 = 1'b1; rdata64_i = rd;
        @(negedge clk);
        rvalid64 = 1'b0; rdata64_i = 64'h0;
        check({nm, " valid"}, valid64, 1'b1);
        check({nm, " rdata"}, rdata64_o, exp);
        check({nm, " err"}, err64, 1'b0);
        req64 = 1'b0;
        @(negedge clk);
        check({nm, " valid pulse"}, valid64, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_na = 1'b1;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = WORD; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        req_na = 1'b0; size_na = WORD; addr_na = 32'h0;
        req64 = 1'b0; size64 = WORD; addr64 = 64'h0; gnt64 = 1'b0; rvalid64 = 1'b0;
        rdata64_i = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst_na = 1'b0;

        check("reset valid", lsu_valid, 1'b0);
        check("reset err", lsu_err, 1'b0);
        check("reset data_req", data_req, 1'b0);
        check("reset rdata", lsu_rdata, 32'h0);

        // LW aligned
        push_beat(1'b0, 32'h100, 4'b1111, 32'h0); rdq.push_back(32'hDEADBEEF);
        do_req(1'b0, WORD, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        // LB / LBU at top lane
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0); rdq.push_back(32'h80000000);
        do_req(1'b0, BYTE, 32'h103, 32'h0, 3, 32'hFFFFFF80, 1'b0);
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0); rdq.push_back(32'h80000000);
        do_req(1'b0, UBYTE, 32'h103, 32'h0, 3, 32'h00000080, 1'b0);
        // LHU, sign bit set but zero-extended
        push_beat(1'b0, 32'h100, 4'b1100, 32'h0); rdq.push_back(32'h80010000);
        do_req(1'b0, UHALF, 32'h102, 32'h0, 3, 32'h00008001, 1'b0);
        // SW split across words
        push_beat(1'b1, 32'h100, 4'b1100, 32'h33440000);
        push_beat(1'b1, 32'h104, 4'b0011, 32'h00001122);
        do_req(1'b1, WORD, 32'h102, 32'h11223344, 5, 32'h0, 1'b0);
        // SB: upper wdata bits must not leak into other lanes
        push_beat(1'b1, 32'h100, 4'b0010, 32'h0000A500);
        do_req(1'b1, BYTE, 32'h101, 32'hFFFFFFA5, 3, 32'h0, 1'b0);
        // LH split
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0); push_beat(1'b0, 32'h104, 4'b0001, 32'h0);
        rdq.push_back(32'hAB000000); rdq.push_back(32'h000000CD);
        do_req(1'b0, HALF, 32'h103, 32'h0, 5, 32'hFFFFCDAB, 1'b0);
        // LH split wrapping the address space
        push_beat(1'b0, 32'hFFFFFFFC, 4'b1000, 32'h0); push_beat(1'b0, 32'h0, 4'b0001, 32'h0);
        rdq.push_back(32'h12000000); rdq.push_back(32'h00000034);
        do_req(1'b0, HALF, 32'hFFFFFFFF, 32'h0, 5, 32'h00003412, 1'b0);
        // Illegal: store UHALF, DWORD on 32-bit
        do_req(1'b1, UHALF, 32'h100, 32'h1234, 1, 32'h0, 1'b1);
        do_req(1'b0, DWORD, 32'h100, 32'h0, 1, 32'h0, 1'b1);

        // Reset while waiting for rvalid
        rv_delay = 1;
        push_beat(1'b0, 32'h200, 4'b1111, 32'h0); rdq.push_back(32'h55555555);
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = WORD; lsu_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; lsu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort data_req", data_req, 1'b0);
        check("abort valid", lsu_valid, 1'b0);
        repeat (3) @(negedge clk);
        rv_delay = 0;
        push_beat(1'b0, 32'h100, 4'b1111, 32'h0); rdq.push_back(32'hCAFEF00D);
        do_req(1'b0, WORD, 32'h100, 32'h0, 3, 32'hCAFEF00D, 1'b0);

        // MISALIGN_EN=0: crossing access errors, exact fit is legal
        @(negedge clk);
        req_na = 1'b1; size_na = HALF; addr_na = 32'h103;
        @(negedge clk);
        check("na err valid", valid_na, 1'b1);
        check("na err flag", err_na, 1'b1);
        check("na no bus", dreq_na, 1'b0);
        req_na = 1'b0;
        @(negedge clk);
        check("na valid pulse", valid_na, 1'b0);
        req_na = 1'b1; addr_na = 32'h102;
        @(negedge clk);
        check("na fit req", dreq_na, 1'b1);
        check("na fit be", be_na, 4'b1100);
        check("na fit valid", valid_na, 1'b0);
        req_na = 1'b0; rst_na = 1'b1;
        @(negedge clk);
        rst_na = 1'b0;
        check("na reset req", dreq_na, 1'b0);

        // 64-bit variants
        t64(UWORD, 64'h4, 64'h80000000_00000000, 8'hF0, 64'h00000000_80000000, "lwu64");
        t64(WORD, 64'h4, 64'h80000000_00000000, 8'hF0, 64'hFFFFFFFF_80000000, "lw64");
        t64(DWORD, 64'h8, 64'h80000000_00000001, 8'hFF, 64'h80000000_00000001, "ld64");

        repeat (3) @(negedge clk);
        check("beats left", beat_q.size(), 0);
        check("completions left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
